key_evt_sched: RTL and testbench

- Multi-key event scheduler between the per-key debouncers and the LED/mode logic.
- Classifies each debounced active-low key into SHORT-press or LONG-press events.
- Holds one pending event per key and shares a single event output port among all keys.
- Output uses round-robin arbitration and a valid/ready handshake.

---
 rtl/key_evt_sched.sv | 183 ++++++++++++++++++
 tb/tb_key_evt_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_evt_sched.sv
// ---------------------------------------------------------------------------
// key_evt_sched
//   Turns debounced active-low keys into SHORT / LONG press events. Each key
//   can hold one pending event. A single registered output slot serves all
//   keys: a round-robin arbiter fills it and a valid/ready handshake drains it.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   key_deb    debounced keys, active-low (0 = pressed)
//   evt_valid  output slot holds an event
//   evt_ready  consumer accepts the event in the slot this cycle
//   evt_key    index of the key that produced the event
//   evt_type   0 = SHORT, 1 = LONG
//   ovf_flag   sticky per-key flag: an event was dropped
//   ovf_clr    synchronous clear of all ovf_flag bits
//
// Parameters: KEY_NUM must be 2..8 and IDX_W >= clog2(KEY_NUM). LONG_CNT is
// the number of cycles a key has to stay pressed before it counts as LONG.
// ---------------------------------------------------------------------------
module key_evt_sched #(
  parameter int              KEY_NUM  = 4,
  parameter int              IDX_W    = 2,
  parameter int              HOLD_W   = 24,
  parameter logic [HOLD_W-1:0] LONG_CNT = 24'd12_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_deb,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDX_W-1:0]   evt_key,
  output logic               evt_type,
  output logic [KEY_NUM-1:0] ovf_flag,
  input  logic               ovf_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD} kstate_t;

  localparam logic [HOLD_W-1:0] LONG_M1 = LONG_CNT - HOLD_W'(1);

  // Per-key state
  kstate_t             state_q [KEY_NUM];
  logic [HOLD_W-1:0]   cnt_q   [KEY_NUM];
  logic [KEY_NUM-1:0]  key_d1_q;
  logic [KEY_NUM-1:0]  pend_q;
  logic [KEY_NUM-1:0]  type_q;
  logic [KEY_NUM-1:0]  ovf_q;

  // Arbiter and output slot
  logic [IDX_W-1:0]    ptr_q;
  logic                evt_valid_q;
  logic [IDX_W-1:0]    evt_key_q;
  logic                evt_type_q;

  // Combinational decode
  logic [KEY_NUM-1:0]  press_v;
  logic [KEY_NUM-1:0]  rel_v;
  logic [KEY_NUM-1:0]  raise;
  logic [KEY_NUM-1:0]  rtype;
  logic [KEY_NUM-1:0]  grant_vec;
  logic [KEY_NUM-1:0]  ovf_d;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    ptr_d;
  logic                found;
  logic                load;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] cand;
    j         = 0;
    cand      = '0;
    press_v   = key_d1_q & ~key_deb;
    rel_v     = ~key_d1_q & key_deb;
    raise     = '0;
    rtype     = '0;
    grant_vec = '0;
    found     = 1'b0;
    gnt_idx   = '0;

    // A key in PRESS raises SHORT on release, else LONG when the hold
    // counter reaches its threshold; release wins.
    for (int k = 0; k < KEY_NUM; k++) begin
      if (state_q[k] == ST_PRESS) begin
        raise[k] = rel_v[k] || (cnt_q[k] == LONG_M1);
        rtype[k] = ~rel_v[k];
      end
    end

    // Round-robin search starting at ptr_q, wrapping at KEY_NUM.
    load = !evt_valid_q || evt_ready;
    for (int i = 0; i < KEY_NUM; i++) begin
      j = int'(ptr_q) + i;
      if (j >= KEY_NUM) j = j - KEY_NUM;
      cand = IDX_W'(j);
      if (!found && pend_q[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (load && found) grant_vec[gnt_idx] = 1'b1;

    ptr_d = (gnt_idx == IDX_W'(KEY_NUM - 1)) ? '0 : gnt_idx + 1'b1;

    // A new overflow beats a simultaneous clear.
    ovf_d = (ovf_clr ? '0 : ovf_q) | (raise & pend_q & ~grant_vec);
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // The sample register resets to "pressed" so a key held across reset
      // must be released and pressed again before it produces an event.
      key_d1_q    <= '0;
      pend_q      <= '0;
      type_q      <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= 1'b0;
      // NOTE: the per-key arrays are a handful of control flops, not RAM,
      // so every element is reset explicitly.
      for (int k = 0; k < KEY_NUM; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      key_d1_q <= key_deb;
      ovf_q    <= ovf_d;

      for (int k = 0; k < KEY_NUM; k++) begin
        case (state_q[k])
          ST_IDLE: begin
            if (press_v[k]) begin
              state_q[k] <= ST_PRESS;
              cnt_q[k]   <= HOLD_W'(1);
            end
          end
          ST_PRESS: begin
            if (rel_v[k])                  state_q[k] <= ST_IDLE;
            else if (cnt_q[k] == LONG_M1)  state_q[k] <= ST_HELD;
            else if (cnt_q[k] != '1)       cnt_q[k]   <= cnt_q[k] + 1'b1;
          end
          ST_HELD: begin
            if (rel_v[k]) state_q[k] <= ST_IDLE;
          end
          default: state_q[k] <= ST_IDLE;
        endcase

        // A pending entry being granted this cycle frees room for a new one.
        if (raise[k] && (!pend_q[k] || grant_vec[k])) begin
          pend_q[k] <= 1'b1;
          type_q[k] <= rtype[k];
        end else if (grant_vec[k]) begin
          pend_q[k] <= 1'b0;
        end
      end

      // Slot is reloaded only when empty or being accepted, so a stalled
      // event stays stable.
      if (load) begin
        if (found) begin
          evt_valid_q <= 1'b1;
          evt_key_q   <= gnt_idx;
          evt_type_q  <= type_q[gnt_idx];
          ptr_q       <= ptr_d;
        end else begin
          evt_valid_q <= 1'b0;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_key   = evt_key_q;
  assign evt_type  = evt_type_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_key_evt_sched.sv
// ---------------------------------------------------------------------------
// tb_key_evt_sched
//   Self-checking bench for key_evt_sched with a short LONG threshold.
//   Expected events are queued as key stimulus is driven; a negedge monitor
//   pops and compares them on every accepted output beat.
// ---------------------------------------------------------------------------
module tb_key_evt_sched;

  localparam int              KEY_NUM  = 4;
  localparam int              IDX_W    = 2;
  localparam int              HOLD_W   = 24;
  localparam logic [HOLD_W-1:0] LONG_CNT = 24'd16;

  logic               clk;
  logic               rst;
  logic [KEY_NUM-1:0] key_deb;
  logic               evt_valid;
  logic               evt_ready;
  logic [IDX_W-1:0]   evt_key;
  logic               evt_type;
  logic [KEY_NUM-1:0] ovf_flag;
  logic               ovf_clr;

  key_evt_sched #(
    .KEY_NUM  (KEY_NUM),
    .IDX_W    (IDX_W),
    .HOLD_W   (HOLD_W),
    .LONG_CNT (LONG_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_deb   (key_deb),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr)
  );

  typedef struct packed {
    logic [IDX_W-1:0] key;
    logic             typ;
  } exp_t;

  exp_t exp_q  [$];
  int   beat_q [$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   edge_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: a beat is accepted at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      beat_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_evt_valid", 32'(evt_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("evt_key", 32'(evt_key), 32'(e.key));
        check("evt_type", 32'(evt_type), 32'(e.typ));
      end
    end
  end

  // All stimulus is applied 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int key, input logic typ);
    exp_t e;
    e.key = IDX_W'(key);
    e.typ = typ;
    exp_q.push_back(e);
  endtask

  // Press the keys in mask for low_cycles, then release; edge_cyc marks the
  // cycle the release was driven.
  task automatic press_mask(input logic [KEY_NUM-1:0] mask, input int low_cycles);
    key_deb = key_deb & ~mask;
    tick(low_cycles);
    key_deb  = key_deb | mask;
    edge_cyc = cyc;
  endtask

  task automatic drain();
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    tick(4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_evt_key"},   32'(evt_key),   32'd0);
    check({tag, "_evt_type"},  32'(evt_type),  32'd0);
    check({tag, "_ovf_flag"},  32'(ovf_flag),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int press_cyc;
    rst       = 1'b1;
    key_deb   = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(3);

    // 1. Short press on key0: one beat two cycles after the release.
    beat_q.delete();
    expect_evt(0, 1'b0);
    press_mask(4'b0001, 5);
    drain();
    check("t1_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() >= 1) check("t1_latency", 32'(beat_q[0] - edge_cyc), 32'd2);
    check("t1_ovf", 32'(ovf_flag), 32'd0);

    // 2. Long press on key2: press sampled at the first edge, LONG raised
    // LONG_CNT-1 edges later, visible one edge after that.
    beat_q.delete();
    expect_evt(2, 1'b1);
    key_deb[2] = 1'b0;
    press_cyc  = cyc;
    tick(40);
    key_deb[2] = 1'b1;
    drain();
    check("t2_beats", 32'(beat_q.size()), 32'd1);
    if (beat_q.size() >= 1)
      check("t2_latency", 32'(beat_q[0] - press_cyc), 32'(int'(LONG_CNT) + 1));

    // Pointer is now 3; a key3 event moves it to 0.
    expect_evt(3, 1'b0);
    press_mask(4'b1000, 3);
    drain();

    // 3a. Keys 0,1,3 released together with pointer 0.
    beat_q.delete();
    expect_evt(0, 1'b0);
    expect_evt(1, 1'b0);
    expect_evt(3, 1'b0);
    press_mask(4'b1011, 3);
    drain();
    check("t3a_beats", 32'(beat_q.size()), 32'd3);
    if (beat_q.size() == 3) begin
      check("t3a_gap0", 32'(beat_q[1] - beat_q[0]), 32'd1);
      check("t3a_gap1", 32'(beat_q[2] - beat_q[1]), 32'd1);
    end

    // A key1 event moves the pointer to 2.
    expect_evt(1, 1'b0);
    press_mask(4'b0010, 3);
    drain();

    // 3b. Same release pattern with pointer 2.
    beat_q.delete();
    expect_evt(3, 1'b0);
    expect_evt(0, 1'b0);
    expect_evt(1, 1'b0);
    press_mask(4'b1011, 3);
    drain();
    check("t3b_beats", 32'(beat_q.size()), 32'd3);

    // 4. Backpressure: slot holds SHORT, pending holds LONG, third dropped.
    evt_ready = 1'b0;
    expect_evt(1, 1'b0);
    press_mask(4'b0010, 3);
    tick(4);
    check("t4_hold_valid", 32'(evt_valid), 32'd1);
    check("t4_hold_key",   32'(evt_key),   32'd1);
    check("t4_hold_type",  32'(evt_type),  32'd0);
    expect_evt(1, 1'b1);
    press_mask(4'b0010, 24);
    tick(3);
    check("t4_no_ovf_yet", 32'(ovf_flag), 32'd0);
    check("t4_stable_key",  32'(evt_key),  32'd1);
    check("t4_stable_type", 32'(evt_type), 32'd0);
    // Third press: its overflow coincides with an ovf_clr pulse.
    key_deb[1] = 1'b0;
    tick(3);
    key_deb[1] = 1'b1;
    ovf_clr    = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_ovf_set", 32'(ovf_flag), 32'b0010);
    check("t4_stable_valid", 32'(evt_valid), 32'd1);
    check("t4_stable_key2",  32'(evt_key),   32'd1);
    evt_ready = 1'b1;
    drain();
    check("t4_ovf_sticky", 32'(ovf_flag), 32'b0010);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf_flag), 32'd0);

    // 5. Reset while key3 is held: no event until a fresh press.
    beat_q.delete();
    key_deb[3] = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(2);
    check_reset_outputs("t5_reset");
    rst = 1'b0;
    tick(30);
    key_deb[3] = 1'b1;
    tick(10);
    check("t5_no_evt", 32'(beat_q.size()), 32'd0);
    expect_evt(3, 1'b0);
    press_mask(4'b1000, 4);
    drain();
    check("t5_beats", 32'(beat_q.size()), 32'd1);

    // 6. Key0's pending is granted in the cycle its next SHORT is raised.
    beat_q.delete();
    evt_ready = 1'b0;
    expect_evt(1, 1'b0);
    press_mask(4'b0010, 3);
    tick(3);
    expect_evt(0, 1'b0);
    press_mask(4'b0001, 3);
    tick(2);
    expect_evt(0, 1'b0);
    key_deb[0] = 1'b0;
    tick(3);
    key_deb[0] = 1'b1;
    evt_ready  = 1'b1;
    drain();
    check("t6_beats", 32'(beat_q.size()), 32'd3);
    check("t6_ovf", 32'(ovf_flag), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
